// File: rtl/pipe_pkg.sv
// Shared constants and types for the decode->execute boundary.
// Control-bundle bit positions, register-file geometry and forward-select encoding.
package pipe_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 4;

   localparam int unsigned CTRL_REGWRITE = 0;
   localparam int unsigned CTRL_MEMTOREG = 1;
   localparam int unsigned CTRL_MEMWRITE = 2;
   localparam int unsigned CTRL_BRANCH   = 3;
   localparam int unsigned CTRL_ALUSRC   = 4;
   localparam int unsigned CTRL_ALUOP_LO = 5;

   localparam logic [REG_AW-1:0] REG_PC = 4'hF;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_W  = 2'd1,
      FWD_M  = 2'd2
   } fwd_sel_t;

   // A later stage supplies the operand when it writes the register being read.
   function automatic logic fwd_hit(input logic [REG_AW-1:0] ra,
                                    input logic [REG_AW-1:0] wa,
                                    input logic              we);
      return we && (wa == ra) && (ra != REG_PC);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode, forward-source, execute and hazard-control signals around the E register.
// The slave view belongs to the stage itself; the master view drives it.
interface id_ex_stage_if
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned CNT_W  = 16
);
   logic [REG_AW-1:0] RA1D, RA2D, WA3D;
   logic [DATA_W-1:0] RD1D, RD2D, ExtImmD;
   logic [CTRL_W-1:0] CtrlD;

   logic [REG_AW-1:0] WA3M, WA3W;
   logic              RegWriteM, RegWriteW;
   logic [DATA_W-1:0] ALUResultM, ResultW;
   logic              BranchTakenE;

   logic [DATA_W-1:0] SrcAE, WriteDataE, ExtImmE;
   logic [REG_AW-1:0] WA3E;
   logic [CTRL_W-1:0] CtrlE;
   logic              ValidE;
   logic              StallF, StallD, FlushD, FlushE;
   logic [CNT_W-1:0]  StallCnt;

   modport master (
      output RA1D, RA2D, WA3D, RD1D, RD2D, ExtImmD, CtrlD,
      output WA3M, WA3W, RegWriteM, RegWriteW, ALUResultM, ResultW, BranchTakenE,
      input  SrcAE, WriteDataE, ExtImmE, WA3E, CtrlE, ValidE,
      input  StallF, StallD, FlushD, FlushE, StallCnt
   );

   modport slave (
      input  RA1D, RA2D, WA3D, RD1D, RD2D, ExtImmD, CtrlD,
      input  WA3M, WA3W, RegWriteM, RegWriteW, ALUResultM, ResultW, BranchTakenE,
      output SrcAE, WriteDataE, ExtImmE, WA3E, CtrlE, ValidE,
      output StallF, StallD, FlushD, FlushE, StallCnt
   );
endinterface

// File: rtl/fwd_sel.sv
// Chooses the source of one execute operand: M result, W result, or the registered read data.
module fwd_sel
   import pipe_pkg::*;
(
   input  logic [REG_AW-1:0] i_rae,
   input  logic [REG_AW-1:0] i_wa3m,
   input  logic [REG_AW-1:0] i_wa3w,
   input  logic              i_regwritem,
   input  logic              i_regwritew,
   output fwd_sel_t          o_sel_c
);

   // M is younger than W, so it wins when both write the same register.
   always_comb begin
      o_sel_c = FWD_RF;
      if (fwd_hit(i_rae, i_wa3m, i_regwritem)) begin
         o_sel_c = FWD_M;
      end else if (fwd_hit(i_rae, i_wa3w, i_regwritew)) begin
         o_sel_c = FWD_W;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with M/W operand forwarding, load-use and branch
// hazard control for F/D, and a saturating count of load-use stall cycles.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned CNT_W  = 16
)(
   input  logic          clk,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);

   logic [DATA_W-1:0] r_rd1e, r_rd2e, r_imme;
   logic [REG_AW-1:0] r_ra1e, r_ra2e, r_wa3e;
   logic [CTRL_W-1:0] r_ctrle;
   logic              r_valide;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_ld_stall;
   logic              w_stall_d;
   logic              w_flush_e;
   fwd_sel_t          w_sel_a, w_sel_b;
   logic [DATA_W-1:0] w_src_a, w_src_b;

   // Load in E whose destination the decode instruction reads; r15 reads come from the PC path.
   assign w_ld_stall = r_ctrle[CTRL_MEMTOREG] && r_valide
                       && ((r_wa3e == bus.RA1D) || (r_wa3e == bus.RA2D))
                       && (r_wa3e != REG_PC);
   assign w_stall_d  = w_ld_stall && !bus.BranchTakenE;
   assign w_flush_e  = w_ld_stall || bus.BranchTakenE;

   always_ff @(posedge clk) begin
      if (reset || w_flush_e) begin
         r_rd1e   <= '0;
         r_rd2e   <= '0;
         r_imme   <= '0;
         r_ra1e   <= '0;
         r_ra2e   <= '0;
         r_wa3e   <= '0;
         r_ctrle  <= '0;
         r_valide <= 1'b0;
      end else begin
         r_rd1e   <= bus.RD1D;
         r_rd2e   <= bus.RD2D;
         r_imme   <= bus.ExtImmD;
         r_ra1e   <= bus.RA1D;
         r_ra2e   <= bus.RA2D;
         r_wa3e   <= bus.WA3D;
         r_ctrle  <= bus.CtrlD;
         r_valide <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall_d && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   fwd_sel u_fwd_a (
      .i_rae       (r_ra1e),
      .i_wa3m      (bus.WA3M),
      .i_wa3w      (bus.WA3W),
      .i_regwritem (bus.RegWriteM),
      .i_regwritew (bus.RegWriteW),
      .o_sel_c     (w_sel_a)
   );

   fwd_sel u_fwd_b (
      .i_rae       (r_ra2e),
      .i_wa3m      (bus.WA3M),
      .i_wa3w      (bus.WA3W),
      .i_regwritem (bus.RegWriteM),
      .i_regwritew (bus.RegWriteW),
      .o_sel_c     (w_sel_b)
   );

   always_comb begin
      w_src_a = r_rd1e;
      w_src_b = r_rd2e;
      case (w_sel_a)
         FWD_M:   w_src_a = bus.ALUResultM;
         FWD_W:   w_src_a = bus.ResultW;
         default: w_src_a = r_rd1e;
      endcase
      case (w_sel_b)
         FWD_M:   w_src_b = bus.ALUResultM;
         FWD_W:   w_src_b = bus.ResultW;
         default: w_src_b = r_rd2e;
      endcase
   end

   assign bus.SrcAE      = w_src_a;
   assign bus.WriteDataE = w_src_b;
   assign bus.ExtImmE    = r_imme;
   assign bus.WA3E       = r_wa3e;
   assign bus.CtrlE      = r_ctrle;
   assign bus.ValidE     = r_valide;
   assign bus.StallF     = w_stall_d;
   assign bus.StallD     = w_stall_d;
   assign bus.FlushD     = bus.BranchTakenE;
   assign bus.FlushE     = w_flush_e;
   assign bus.StallCnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of single-cycle vectors with a scoreboard queue for E
// outputs, plus hand-written reset, counter-saturation and reset-during-stall sequences.
module tb_id_ex_stage;

   localparam int unsigned CTRL_W = 8;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned NVEC   = 12;

   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

   id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ra1d, ra2d, wa3d;
      logic [31:0] rd1d, rd2d, imm;
      logic [7:0]  ctrl;
      logic        rwm;
      logic [3:0]  wa3m;
      logic [31:0] alum;
      logic        rww;
      logic [3:0]  wa3w;
      logic [31:0] resw;
      logic        br;
      logic        x_stall, x_flushd, x_flushe;
      logic [31:0] x_srca, x_wdata, x_imm;
      logic [3:0]  x_wa3;
      logic [7:0]  x_ctrl;
      logic        x_valid;
      logic [5:0]  x_cnt;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] srca, wdata, imm;
      logic [3:0]  wa3;
      logic [7:0]  ctrl;
      logic        valid;
      logic [5:0]  cnt;
   } exp_t;

   vec_t vecs [NVEC];
   exp_t sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      bus.RA1D = v.ra1d;  bus.RA2D = v.ra2d;  bus.WA3D = v.wa3d;
      bus.RD1D = v.rd1d;  bus.RD2D = v.rd2d;  bus.ExtImmD = v.imm;
      bus.CtrlD = v.ctrl;
      bus.RegWriteM = v.rwm;  bus.WA3M = v.wa3m;  bus.ALUResultM = v.alum;
      bus.RegWriteW = v.rww;  bus.WA3W = v.wa3w;  bus.ResultW = v.resw;
      bus.BranchTakenE = v.br;
   endtask

   task automatic check_e(input string tag, input exp_t e);
      check($sformatf("%s SrcAE", tag),      bus.SrcAE,      e.srca);
      check($sformatf("%s WriteDataE", tag), bus.WriteDataE, e.wdata);
      check($sformatf("%s ExtImmE", tag),    bus.ExtImmE,    e.imm);
      check($sformatf("%s WA3E", tag),       32'(bus.WA3E),  32'(e.wa3));
      check($sformatf("%s CtrlE", tag),      32'(bus.CtrlE), 32'(e.ctrl));
      check($sformatf("%s ValidE", tag),     32'(bus.ValidE), 32'(e.valid));
      check($sformatf("%s StallCnt", tag),   32'(bus.StallCnt), 32'(e.cnt));
   endtask

   initial begin
      exp_t e;
      exp_t zero_e;

      //        ra1 ra2 wa3 rd1      rd2     imm    ctrl   rwm wa3m alum    rww wa3w resw    br  stl fd fe  srca     wdata   imm    wa3 ctrl   v  cnt
      vecs[0]  = '{1,  2,  2,  'h11,   'h22,   'h4,   'h01,  0,  0,   0,      0,  0,   0,      0,  0,  0, 0,  'h11,   'h22,   'h4,   2,  'h01,  1, 0};
      vecs[1]  = '{3,  4,  6,  'h33,   'h44,   'h8,   'h01,  1,  3,   'hAA,   1,  3,   'hBB,   0,  0,  0, 0,  'hAA,   'h44,   'h8,   6,  'h01,  1, 0};
      vecs[2]  = '{3,  4,  6,  'h33,   'h44,   'h8,   'h01,  0,  3,   'hAA,   1,  3,   'hBB,   0,  0,  0, 0,  'hBB,   'h44,   'h8,   6,  'h01,  1, 0};
      vecs[3]  = '{15, 3,  7,  'h1F0,  'h55,   0,     'h04,  1,  15,  'hAA,   1,  3,   'hBB,   0,  0,  0, 0,  'h1F0,  'hBB,   0,     7,  'h04,  1, 0};
      vecs[4]  = '{9,  9,  8,  'h99,   'h98,   'hC,   'h01,  1,  9,   'hA9,   1,  9,   'hB9,   0,  0,  0, 0,  'hA9,   'hA9,   'hC,   8,  'h01,  1, 0};
      vecs[5]  = '{1,  0,  5,  'h100,  0,      'h10,  'h03,  0,  0,   0,      0,  0,   0,      0,  0,  0, 0,  'h100,  0,      'h10,  5,  'h03,  1, 0};
      vecs[6]  = '{6,  5,  7,  'h66,   'h55,   1,     'h01,  0,  0,   0,      0,  0,   0,      0,  1,  0, 1,  0,      0,      0,     0,  0,     0, 1};
      vecs[7]  = '{6,  5,  7,  'h66,   'h55,   1,     'h01,  0,  0,   0,      0,  0,   0,      0,  0,  0, 0,  'h66,   'h55,   1,     7,  'h01,  1, 1};
      vecs[8]  = '{2,  3,  5,  'h20,   'h30,   0,     'h03,  0,  0,   0,      0,  0,   0,      0,  0,  0, 0,  'h20,   'h30,   0,     5,  'h03,  1, 1};
      vecs[9]  = '{5,  1,  4,  'h50,   'h10,   2,     'h01,  0,  0,   0,      0,  0,   0,      1,  0,  1, 1,  0,      0,      0,     0,  0,     0, 1};
      vecs[10] = '{0,  0,  15, 7,      8,      0,     'h03,  0,  0,   0,      0,  0,   0,      0,  0,  0, 0,  7,      8,      0,     15, 'h03,  1, 1};
      vecs[11] = '{15, 15, 1,  'hF0,   'hF1,   0,     'h01,  0,  0,   0,      0,  0,   0,      0,  0,  0, 0,  'hF0,   'hF1,   0,     1,  'h01,  1, 1};

      zero_e = '{-1, 0, 0, 0, 0, 0, 0, 0};

      // Reset held for two cycles with random decode inputs; M/W sources idle.
      reset = 1'b1;
      apply(vecs[0]);
      bus.RegWriteM = 1'b0;  bus.RegWriteW = 1'b0;  bus.BranchTakenE = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         bus.RA1D = 4'($urandom);  bus.RA2D = 4'($urandom);  bus.WA3D = 4'($urandom);
         bus.RD1D = $urandom;      bus.RD2D = $urandom;      bus.ExtImmD = $urandom;
         bus.CtrlD = 8'($urandom);
         @(posedge clk);
         #1;
      end
      check_e("reset", zero_e);
      check("reset StallD", 32'(bus.StallD), 32'd0);
      check("reset FlushE", 32'(bus.FlushE), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Vector table: hazard outputs checked before the edge, E outputs via the scoreboard after it.
      for (int i = 0; i < int'(NVEC); i++) begin
         apply(vecs[i]);
         sb.push_back('{i, vecs[i].x_srca, vecs[i].x_wdata, vecs[i].x_imm, vecs[i].x_wa3,
                        vecs[i].x_ctrl, vecs[i].x_valid, vecs[i].x_cnt});
         #1;
         check($sformatf("v%0d StallF", i), 32'(bus.StallF), 32'(vecs[i].x_stall));
         check($sformatf("v%0d StallD", i), 32'(bus.StallD), 32'(vecs[i].x_stall));
         check($sformatf("v%0d FlushD", i), 32'(bus.FlushD), 32'(vecs[i].x_flushd));
         check($sformatf("v%0d FlushE", i), 32'(bus.FlushE), 32'(vecs[i].x_flushe));
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check_e($sformatf("v%0d", e.idx), e);
         @(negedge clk);
      end

      // Self-dependent load: stalls on every second edge, so 2*(2^CNT_W+3) edges give 67 stalls.
      reset = 1'b1;
      apply(vecs[0]);
      bus.RA1D = 4'd5;  bus.RA2D = 4'd0;  bus.WA3D = 4'd5;  bus.CtrlD = 8'h03;
      @(posedge clk);
      #1;
      check("sat reset StallCnt", 32'(bus.StallCnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 134; k++) begin
         @(posedge clk);
         #1;
         if (k == 124) check("sat k124 StallCnt", 32'(bus.StallCnt), 32'd62);
         if (k == 126) check("sat k126 StallCnt", 32'(bus.StallCnt), 32'd63);
         if (k == 134) check("sat k134 StallCnt", 32'(bus.StallCnt), 32'd63);
      end

      // Load re-enters E, stall is pending; reset on that edge clears everything.
      @(posedge clk);
      #1;
      check("pre-rst ValidE", 32'(bus.ValidE), 32'd1);
      check("pre-rst StallD", 32'(bus.StallD), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid-stall rst StallCnt", 32'(bus.StallCnt), 32'd0);
      check("mid-stall rst ValidE", 32'(bus.ValidE), 32'd0);
      check("mid-stall rst CtrlE", 32'(bus.CtrlE), 32'd0);
      check("mid-stall rst StallD", 32'(bus.StallD), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post-rst ValidE", 32'(bus.ValidE), 32'd1);
      check("post-rst CtrlE", 32'(bus.CtrlE), 32'h03);
      check("post-rst StallD", 32'(bus.StallD), 32'd1);
      check("post-rst StallCnt", 32'(bus.StallCnt), 32'd0);
      @(posedge clk);
      #1;
      check("post-stall StallCnt", 32'(bus.StallCnt), 32'd1);
      check("post-stall ValidE", 32'(bus.ValidE), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
